// File: rtl/key_cursor_ctrl_pkg.sv
// Shared keyboard definitions: decoded key codes, cursor FSM states and sizing helpers.
package key_cursor_ctrl_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    UP    = 4'd1,
    DOWN  = 4'd2,
    LEFT  = 4'd3,
    RIGHT = 4'd4,
    COLOR = 4'd5,
    HOME  = 4'd6
  } key_code_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_e;

  // Codes above HOME are reserved by the keyboard controller and mean "no key".
  function automatic key_code_e decode_key(input logic [3:0] raw);
    return (raw > 4'd6) ? NONE : key_code_e'(raw);
  endfunction

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_cursor_ctrl_if.sv
// Control/status bundle between the cursor FSM and its repeat timer.
interface repeat_timer_if;
  logic clr;
  logic inc;
  logic sel_rate;
  logic tc;

  modport ctrl  (output clr, output inc, output sel_rate, input  tc);
  modport timer (input  clr, input  inc, input  sel_rate, output tc);
endinterface

// File: rtl/key_cursor_ctrl_repeat_timer.sv
// Auto-repeat counter: counts up on request, flags the terminal count of the selected period.
module repeat_timer
  import key_cursor_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic           clock,
  input  logic           reset,
  repeat_timer_if.timer  bus
);

  localparam int W = cnt_width(REPEAT_DELAY, REPEAT_RATE);

  logic [W-1:0] cnt;
  logic [W-1:0] limit;

  assign limit  = bus.sel_rate ? W'(REPEAT_RATE - 1) : W'(REPEAT_DELAY - 1);
  assign bus.tc = (cnt == limit);

  // The controller clears on terminal count, so the counter never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       cnt <= '0;
    else if (bus.clr) cnt <= '0;
    else if (bus.inc) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/key_cursor_ctrl.sv
// Keyboard-driven text cursor: glitch-filtered key codes, press/hold/auto-repeat FSM, wrap-around moves.
module key_cursor_ctrl
  import key_cursor_ctrl_pkg::*;
#(
  parameter int COLS         = 80,
  parameter int ROWS         = 60,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keyCode,
  output logic [6:0] cursorX,
  output logic [5:0] cursorY,
  output logic [2:0] color,
  output logic       moved
);

  logic [3:0] code_q;
  logic       filt_vld;
  key_code_e  filt_code;
  key_code_e  held, held_nxt;
  state_e     state, state_nxt;
  logic       act;
  logic       tmr_clr, tmr_inc;

  repeat_timer_if tmr ();

  assign tmr.clr      = tmr_clr;
  assign tmr.inc      = tmr_inc;
  assign tmr.sel_rate = (state == REPEAT);

  repeat_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .bus   (tmr)
  );

  // A code is trusted only once it matches the previous cycle; the verdict is registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      code_q    <= '0;
      filt_vld  <= 1'b0;
      filt_code <= NONE;
    end else begin
      code_q    <= keyCode;
      filt_vld  <= (keyCode == code_q);
      filt_code <= decode_key(keyCode);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      held  <= NONE;
    end else begin
      state <= state_nxt;
      held  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    held_nxt  = held;
    act       = 1'b0;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        if (filt_vld && filt_code != NONE) begin
          act       = 1'b1;
          held_nxt  = filt_code;
          state_nxt = HOLD;
        end
      end
      HOLD, REPEAT: begin
        // Unstable input leaves state and count untouched.
        if (filt_vld) begin
          if (filt_code == NONE) begin
            tmr_clr   = 1'b1;
            state_nxt = IDLE;
          end else if (filt_code != held) begin
            act       = 1'b1;
            held_nxt  = filt_code;
            tmr_clr   = 1'b1;
            state_nxt = HOLD;
          end else if (tmr.tc) begin
            act       = 1'b1;
            tmr_clr   = 1'b1;
            state_nxt = REPEAT;
          end else begin
            tmr_inc = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Every applied action is the currently filtered code, including repeats of the held key.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cursorX <= '0;
      cursorY <= '0;
      color   <= 3'b111;
      moved   <= 1'b0;
    end else begin
      moved <= act;
      if (act) begin
        case (filt_code)
          UP:    cursorY <= (cursorY == '0) ? 6'(ROWS - 1) : cursorY - 6'd1;
          DOWN:  cursorY <= (cursorY == 6'(ROWS - 1)) ? '0 : cursorY + 6'd1;
          LEFT:  cursorX <= (cursorX == '0) ? 7'(COLS - 1) : cursorX - 7'd1;
          RIGHT: cursorX <= (cursorX == 7'(COLS - 1)) ? '0 : cursorX + 7'd1;
          COLOR: color   <= color + 3'd1;
          HOME: begin
            cursorX <= '0;
            cursorY <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/key_cursor_ctrl.md
KEY_CURSOR_CTRL -- requirements
Module: key_cursor_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, number of character columns (cursorX range 0..COLS-1).
REQ-002 SHALL have parameter ROWS, default 60, number of character rows (cursorY range 0..ROWS-1).
REQ-003 SHALL have parameter REPEAT_DELAY, default 25000000, number of clock cycles a key is held before the first auto-repeat.
REQ-004 SHALL have parameter REPEAT_RATE, default 5000000, number of clock cycles between subsequent auto-repeats.
REQ-005 SHALL have port clock, input, 1 bit; the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit; asynchronous, active-low reset.
REQ-007 SHALL have port keyCode, input, 4 bits; decoded key code from the keyboard controller outCode, same clock domain.
REQ-008 SHALL have port cursorX, output, 7 bits; current cursor column.
REQ-009 SHALL have port cursorY, output, 6 bits; current cursor row.
REQ-010 SHALL have port color, output, 3 bits; current RGB drawing colour.
REQ-011 SHALL have port moved, output, 1 bit; one-cycle pulse on any cursor or colour update.

Function
REQ-012 SHALL interpret keyCode as follows: 0 none, 1 up, 2 down, 3 left, 4 right, 5 next colour, 6 home; codes 7..15 SHALL be treated as none.
REQ-013 SHALL register keyCode every cycle (codeQ) and treat a code as valid only when keyCode equals codeQ (2-cycle glitch filter).
REQ-014 SHALL implement the FSM states IDLE, HOLD and REPEAT.
REQ-015 In IDLE, a valid non-none code SHALL apply its action once, latch the code, clear the counter and enter HOLD.
REQ-016 For the action latency: with the code first present before edge n, filter agreement occurs at edge n+1 and outputs and moved SHALL update at edge n+2.
REQ-017 In HOLD, the counter SHALL increment each cycle; when it reaches REPEAT_DELAY-1 the action SHALL be applied again, the counter cleared and the FSM SHALL enter REPEAT.
REQ-018 In REPEAT, the action SHALL be applied each time the counter reaches REPEAT_RATE-1, after which the counter SHALL be cleared.
REQ-019 In HOLD or REPEAT, if the valid code becomes none, the FSM SHALL go to IDLE with no action; if it becomes a different non-none code, that code's action SHALL apply at once and the FSM SHALL re-enter HOLD with the counter cleared.
REQ-020 In HOLD or REPEAT, an invalid (unstable) input SHALL hold the state and freeze the counter.
REQ-021 Up SHALL decrement cursorY, wrapping from 0 to ROWS-1; down SHALL increment it, wrapping from ROWS-1 to 0.
REQ-022 Left SHALL decrement cursorX, wrapping from 0 to COLS-1; right SHALL increment it, wrapping from COLS-1 to 0.
REQ-023 Next colour SHALL increment color modulo 8.
REQ-024 Home SHALL set cursorX=0 and cursorY=0 and leave color unchanged.
REQ-025 moved SHALL be high exactly in the cycle after each applied action, including home at 0,0, and low otherwise.
REQ-026 The counter SHALL be wide enough for max(REPEAT_DELAY, REPEAT_RATE) and SHALL never wrap.

Reset
REQ-027 Asserting reset (low) SHALL asynchronously force: cursorX=0, cursorY=0, color=3'b111, moved=0, codeQ=0, counter=0, FSM=IDLE.
REQ-028 A key held through reset deassertion SHALL be handled as a fresh press: one action at most 2 cycles after release, then HOLD.
REQ-029 Reset asserted mid-HOLD or mid-REPEAT SHALL abort the pending repeat with no further action.

Structure
REQ-030 The key-code constants (NONE, UP, DOWN, LEFT, RIGHT, COLOR, HOME) and the FSM state encoding SHALL live in a shared keyboard package, also used by the decoder.
REQ-031 The repeat timer (counter, terminal-count compare, clear) SHALL be one sub-module, repeat_timer, instantiated once.

Verification (REPEAT_DELAY=8, REPEAT_RATE=4, COLS=80, ROWS=60)
REQ-032 Release reset, hold keyCode=4 for 3 cycles, then 0 -> cursorX=1, a single moved pulse at edge n+2, cursorY=0, color=7.
REQ-033 Hold keyCode=3 for 30 cycles from reset -> first press gives cursorX=79, then cursorX=78 after 8 more cycles, and a further decrement every 4 cycles (repeat timing exact).
REQ-034 Apply a 1-cycle glitch keyCode=2 between zeros -> no moved pulse and cursorY stays 0.
REQ-035 With cursorY=59, press 2 -> cursorY=0; press 5 with color=7 -> color=0; with the cursor at (10,5), press 6 -> (0,0) and moved still pulses.
REQ-036 Switch directly from a held 1 to 4 while in REPEAT -> the right action applies immediately and HOLD restarts (next repeat 8 cycles later).
REQ-037 Assert reset mid-REPEAT with key 4 still held -> outputs reset immediately; after deassertion exactly one increment, then HOLD timing.
